sram_controller: RTL and testbench



---
 rtl/sram_controller_pkg.sv | 30 +++
 rtl/sram_wait_counter.sv | 35 +++
 rtl/sram_controller.sv | 160 ++++++++++++++++
 tb/tb_sram_controller.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM memory-stage controller: request bit positions,
// default timing parameters and the 3-bit sequencer state encoding.
package sram_controller_pkg;

    // Bit positions inside mem_signals.
    localparam int unsigned MEM_R_BIT = 1;
    localparam int unsigned MEM_W_BIT = 0;

    // Defaults: data memory base address and extra hold cycles per half-word phase.
    localparam int unsigned DEFAULT_BASE_ADDR   = 1024;
    localparam int unsigned DEFAULT_WAIT_CYCLES = 1;

    // 3-bit state encoding.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RD_LO = 3'd1;
    localparam logic [2:0] ST_RD_HI = 3'd2;
    localparam logic [2:0] ST_WR_LO = 3'd3;
    localparam logic [2:0] ST_WR_HI = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        StIdle = ST_IDLE,
        StRdLo = ST_RD_LO,
        StRdHi = ST_RD_HI,
        StWrLo = ST_WR_LO,
        StWrHi = ST_WR_HI,
        StDone = ST_DONE
    } state_e;

endpackage

// File: rtl/sram_wait_counter.sv
// Per-phase wait-state counter. Cleared on every phase entry; last_o marks the final
// cycle of a phase (count == WAIT_CYCLES).
module sram_wait_counter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic last_o
);

    localparam logic [2:0] LastCount = 3'(WAIT_CYCLES);

    logic [2:0] count_q, count_d;

    // Next count: restart on clear, otherwise advance.
    always_comb begin
        count_d = count_q + 3'd1;
        if (clear_i) begin
            count_d = 3'd0;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= 3'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_o = (count_q == LastCount);

endmodule

// File: rtl/sram_controller.sv
// MEM-stage sequencer for a 16-bit asynchronous SRAM. Each 32-bit load/store is split
// into a low and a high half-word access of WAIT_CYCLES+1 cycles each; ready is low
// while a transaction is in flight so the pipeline freezes.
// Optional: define SRAM_STALL_CNT_EN to add a saturating stall_count output.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         mem_signals,
    input  logic [31:0]        address,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    inout  wire  [15:0]        sram_dq,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
`ifdef SRAM_STALL_CNT_EN
    ,
    output logic [31:0]        stall_count
`endif
);

    localparam int unsigned IdxW = SRAM_AW - 1;
    // With no wait states the single write cycle must keep we_n low.
    localparam logic WeRelease = (WAIT_CYCLES != 0);

    state_e          state_q, state_d;
    logic [IdxW-1:0] index_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q;
    logic [15:0]     lo_q;
    logic [31:0]     offset;
    logic            last;
    logic            ctr_clear;
    logic            req_rd, req_wr;
    logic            dq_oe;
    logic [15:0]     dq_out;

    assign offset = address - 32'(BASE_ADDR);
    assign req_rd = mem_signals[MEM_R_BIT] & ~mem_signals[MEM_W_BIT];
    assign req_wr = mem_signals[MEM_W_BIT] & ~mem_signals[MEM_R_BIT];

    // Any state change is a phase entry, so the counter starts each phase at zero.
    assign ctr_clear = (state_d != state_q);

    sram_wait_counter #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_wait_counter (
        .clk_i  (clk),
        .rst_i  (rst),
        .clear_i(ctr_clear),
        .last_o (last)
    );

    // Next-state and SRAM control decode.
    always_comb begin
        state_d   = state_q;
        ready     = 1'b0;
        sram_ce_n = 1'b1;
        sram_oe_n = 1'b1;
        sram_we_n = 1'b1;
        sram_ub_n = 1'b1;
        sram_lb_n = 1'b1;
        sram_addr = '0;
        dq_oe     = 1'b0;
        dq_out    = 16'h0000;
        unique case (state_q)
            StIdle: begin
                ready = ~(req_rd | req_wr);
                if (req_rd) begin
                    state_d = StRdLo;
                end else if (req_wr) begin
                    state_d = StWrLo;
                end
            end
            StRdLo, StRdHi: begin
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_addr = {index_q, (state_q == StRdHi)};
                if (last) begin
                    state_d = (state_q == StRdLo) ? StRdHi : StDone;
                end
            end
            StWrLo, StWrHi: begin
                sram_ce_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
                sram_we_n = last & WeRelease;
                sram_addr = {index_q, (state_q == StWrHi)};
                dq_oe     = 1'b1;
                dq_out    = (state_q == StWrHi) ? wdata_q[31:16] : wdata_q[15:0];
                if (last) begin
                    state_d = (state_q == StWrLo) ? StWrHi : StDone;
                end
            end
            StDone: begin
                // Unconditional return so a still-presented request is not reissued here.
                ready   = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, request latches and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            index_q <= '0;
            wdata_q <= 32'h0;
            lo_q    <= 16'h0;
            rdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && state_d != StIdle) begin
                index_q <= offset[SRAM_AW:2];
                wdata_q <= wdata;
            end
            // Low half is staged so an aborted read never leaves rdata half-updated.
            if (state_q == StRdLo && last) begin
                lo_q <= sram_dq;
            end
            if (state_q == StRdHi && last) begin
                rdata_q <= {sram_dq, lo_q};
            end
        end
    end

    assign sram_dq = dq_oe ? dq_out : 16'bz;
    assign rdata   = rdata_q;

`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count frozen cycles, pinned at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q <= 32'h0;
        end else if (!ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: a default (WAIT_CYCLES=1) instance and a WAIT_CYCLES=0
// instance, each with a behavioural async SRAM. Expected per-cycle bus states and load
// results are queued when a request is driven and popped as the cycles complete.
module tb_sram_controller;

    typedef struct packed {
        logic        rdy;
        logic        ce_n;
        logic        oe_n;
        logic        we_n;
        logic        ub_n;
        logic        lb_n;
        logic [17:0] a;
        logic [15:0] d;
    } obs_t;

    typedef struct packed {
        obs_t o;
        logic chk_d;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  ms, ms_w0;
    logic [31:0] addr, addr_w0, wdata;
    wire  [15:0] dq, dq_w0;
    logic [31:0] rdata, rdata_w0;
    logic        ready, ready_w0;
    logic [17:0] sa, sa_w0;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;
    logic        we_n_w0, oe_n_w0, ce_n_w0, ub_n_w0, lb_n_w0;
`ifdef SRAM_STALL_CNT_EN
    logic [31:0] stall, stall_w0;
`endif

    sram_controller u_dut (
        .clk        (clk),
        .rst        (rst),
        .mem_signals(ms),
        .address    (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .ready      (ready),
        .sram_dq    (dq),
        .sram_addr  (sa),
        .sram_we_n  (we_n),
        .sram_oe_n  (oe_n),
        .sram_ce_n  (ce_n),
        .sram_ub_n  (ub_n),
        .sram_lb_n  (lb_n)
`ifdef SRAM_STALL_CNT_EN
        ,
        .stall_count(stall)
`endif
    );

    sram_controller #(
        .WAIT_CYCLES(0)
    ) u_dut_w0 (
        .clk        (clk),
        .rst        (rst),
        .mem_signals(ms_w0),
        .address    (addr_w0),
        .wdata      (32'h0),
        .rdata      (rdata_w0),
        .ready      (ready_w0),
        .sram_dq    (dq_w0),
        .sram_addr  (sa_w0),
        .sram_we_n  (we_n_w0),
        .sram_oe_n  (oe_n_w0),
        .sram_ce_n  (ce_n_w0),
        .sram_ub_n  (ub_n_w0),
        .sram_lb_n  (lb_n_w0)
`ifdef SRAM_STALL_CNT_EN
        ,
        .stall_count(stall_w0)
`endif
    );

    // Behavioural SRAMs: read drives the bus while selected with oe_n low.
    logic [15:0] mem    [0:255];
    logic [15:0] mem_w0 [0:255];

    assign dq    = (!ce_n && !oe_n && we_n) ? mem[sa[7:0]] : 16'bz;
    assign dq_w0 = (!ce_n_w0 && !oe_n_w0 && we_n_w0) ? mem_w0[sa_w0[7:0]] : 16'bz;

    always @(posedge clk) begin
        if (!ce_n && !we_n) mem[sa[7:0]] <= dq;
    end

    obs_t obs, obs_w0;
    assign obs    = {ready, ce_n, oe_n, we_n, ub_n, lb_n, sa, dq};
    assign obs_w0 = {ready_w0, ce_n_w0, oe_n_w0, we_n_w0, ub_n_w0, lb_n_w0, sa_w0, dq_w0};

    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t exp_q[$];
    logic [31:0] rd_q[$];

    function automatic exp_t e_idle(input logic rdy);
        exp_t e;
        e.o     = {rdy, 5'b11111, 18'd0, 16'd0};
        e.chk_d = 1'b0;
        return e;
    endfunction

    function automatic exp_t e_rd(input logic [17:0] a, input logic [15:0] d);
        exp_t e;
        e.o     = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a, d};
        e.chk_d = 1'b1;
        return e;
    endfunction

    function automatic exp_t e_wr(input logic [17:0] a, input logic [15:0] d, input logic w);
        exp_t e;
        e.o     = {1'b0, 1'b0, 1'b1, w, 1'b0, 1'b0, a, d};
        e.chk_d = 1'b1;
        return e;
    endfunction

    task automatic test_reset;
        obs_t got;
        rst = 1'b1;
        ms = 2'b00;
        ms_w0 = 2'b00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        got = obs;
        got.d = '0;
        n_tests++;
        if (got !== e_idle(1'b1).o || rdata !== 32'h0 || ready_w0 !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_state: got %h rdata %h rdy_w0 %b want %h rdata 0 rdy_w0 1",
                     got, rdata, ready_w0, e_idle(1'b1).o);
        end
        // Start a load and abort it in the high phase.
        @(posedge clk);
        #1 ms = 2'b10;
        addr = 32'd1028;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (obs !== e_rd(18'd3, mem[3]).o) begin
            n_fail++;
            $display("FAIL reset_pre_rdhi: got %h want %h", obs, e_rd(18'd3, mem[3]).o);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        ms = 2'b00;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1 if (c == 1) rst = 1'b0;
            @(negedge clk);
            got = obs;
            got.d = '0;
            n_tests++;
            if (got !== e_idle(1'b1).o || rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_abort c%0d: got %h rdata %h want %h rdata 0",
                         c, got, rdata, e_idle(1'b1).o);
            end
        end
    endtask

    task automatic test_write;
        exp_t e;
        obs_t got;
        exp_q.push_back(e_idle(1'b0));
        exp_q.push_back(e_wr(18'd2, 16'hBEEF, 1'b0));
        exp_q.push_back(e_wr(18'd2, 16'hBEEF, 1'b1));
        exp_q.push_back(e_wr(18'd3, 16'hDEAD, 1'b0));
        exp_q.push_back(e_wr(18'd3, 16'hDEAD, 1'b1));
        exp_q.push_back(e_idle(1'b1));
        @(posedge clk);
        #1 ms = 2'b01;
        addr = 32'd1028;
        wdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 5) ms = 2'b00;
            @(negedge clk);
            e = exp_q.pop_front();
            got = obs;
            if (!e.chk_d) got.d = '0;
            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL write c%0d: got %h want %h", c, got, e.o);
            end
        end
        n_tests++;
        if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL write_mem: got %h %h rdata %h want beef dead rdata 0",
                     mem[2], mem[3], rdata);
        end
    endtask

    task automatic test_read;
        exp_t e;
        obs_t got;
        logic [31:0] want;
        rd_q.push_back(32'hDEAD_BEEF);
        exp_q.push_back(e_idle(1'b0));
        exp_q.push_back(e_rd(18'd2, 16'hBEEF));
        exp_q.push_back(e_rd(18'd2, 16'hBEEF));
        exp_q.push_back(e_rd(18'd3, 16'hDEAD));
        exp_q.push_back(e_rd(18'd3, 16'hDEAD));
        exp_q.push_back(e_idle(1'b1));
        @(posedge clk);
        #1 ms = 2'b10;
        addr = 32'd1028;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 5) ms = 2'b00;
            @(negedge clk);
            e = exp_q.pop_front();
            got = obs;
            if (!e.chk_d) got.d = '0;
            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL read c%0d: got %h want %h", c, got, e.o);
            end
            if (c == 5) begin
                want = rd_q.pop_front();
                n_tests++;
                if (rdata !== want) begin
                    n_fail++;
                    $display("FAIL read_data: got %h want %h", rdata, want);
                end
            end
        end
    endtask

    // Load held through DONE and one idle cycle: the idle cycle issues a second read.
    task automatic test_held_request;
        exp_t e;
        obs_t got;
        logic [31:0] want;
        for (int k = 0; k < 2; k++) begin
            rd_q.push_back(32'hDEAD_BEEF);
            exp_q.push_back(e_idle(1'b0));
            exp_q.push_back(e_rd(18'd2, 16'hBEEF));
            exp_q.push_back(e_rd(18'd2, 16'hBEEF));
            exp_q.push_back(e_rd(18'd3, 16'hDEAD));
            exp_q.push_back(e_rd(18'd3, 16'hDEAD));
            exp_q.push_back(e_idle(1'b1));
        end
        exp_q.push_back(e_idle(1'b1));
        @(posedge clk);
        #1 ms = 2'b10;
        addr = 32'd1028;
        for (int c = 0; c < 13; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 7) ms = 2'b00;
            @(negedge clk);
            e = exp_q.pop_front();
            got = obs;
            if (!e.chk_d) got.d = '0;
            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL held c%0d: got %h want %h", c, got, e.o);
            end
            if (c == 5 || c == 11) begin
                want = rd_q.pop_front();
                n_tests++;
                if (rdata !== want) begin
                    n_fail++;
                    $display("FAIL held_data c%0d: got %h want %h", c, rdata, want);
                end
            end
        end
    endtask

    task automatic test_nop;
        exp_t e;
        obs_t got;
        for (int c = 0; c < 20; c++) exp_q.push_back(e_idle(1'b1));
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1 ms = (c < 10) ? 2'b11 : 2'b00;
            addr = 32'd1028;
            @(negedge clk);
            e = exp_q.pop_front();
            got = obs;
            got.d = '0;
            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL nop ms=%b c%0d: got %h want %h", ms, c, got, e.o);
            end
        end
        ms = 2'b00;
    endtask

    task automatic test_wait0;
        exp_t e;
        obs_t got;
        logic [31:0] want;
        rd_q.push_back(32'hCAFE_5678);
        exp_q.push_back(e_idle(1'b0));
        exp_q.push_back(e_rd(18'd4, 16'h5678));
        exp_q.push_back(e_rd(18'd5, 16'hCAFE));
        exp_q.push_back(e_idle(1'b1));
        @(posedge clk);
        #1 ms_w0 = 2'b10;
        addr_w0 = 32'd1032;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) begin
                @(posedge clk);
                #1;
            end
            if (c == 3) ms_w0 = 2'b00;
            @(negedge clk);
            e = exp_q.pop_front();
            got = obs_w0;
            if (!e.chk_d) got.d = '0;
            n_tests++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL wait0 c%0d: got %h want %h", c, got, e.o);
            end
            if (c == 3) begin
                want = rd_q.pop_front();
                n_tests++;
                if (rdata_w0 !== want) begin
                    n_fail++;
                    $display("FAIL wait0_data: got %h want %h", rdata_w0, want);
                end
`ifdef SRAM_STALL_CNT_EN
                n_tests++;
                if (stall_w0 !== 32'd3) begin
                    n_fail++;
                    $display("FAIL wait0_stall: got %0d want 3", stall_w0);
                end
`endif
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        ms = 2'b00;
        ms_w0 = 2'b00;
        addr = 32'd0;
        addr_w0 = 32'd0;
        wdata = 32'd0;
        mem_w0[4] = 16'h5678;
        mem_w0[5] = 16'hCAFE;
        test_reset();
        test_write();
        test_read();
        test_held_request();
        test_nop();
        test_wait0();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
